// File: rtl/pattern_frame_tx.sv
// Serial frame transmitter: sends PREAMBLE, then the latched word MSB-first, then one
// gap bit. The line outputs are registered from the next state, so they never depend on inputs.
module pattern_frame_tx #(
  parameter int                 DATA_W   = 8,
  parameter int                 PRE_LEN  = 3,
  parameter logic [PRE_LEN-1:0] PREAMBLE = 3'b010,
  parameter logic               IDLE_BIT = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out,
  output logic              busy,
  output logic              frame_done
);

  localparam int MAX_LEN = (PRE_LEN > DATA_W) ? PRE_LEN : DATA_W;
  localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PRE_LEN - 1);
  localparam logic [CNT_W-1:0] DAT_LOAD = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_GAP
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                out_q, out_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [PRE_LEN-1:0]  pre_sh;
  logic                accept;

  // Decoded from the state register only, so there is no path from in_valid to in_ready.
  assign in_ready   = (state_q == S_IDLE) || (state_q == S_GAP);
  assign accept     = in_valid && in_ready;
  assign out        = out_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

  // NOTE: every signal written here gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    unique case (state_q)
      S_IDLE, S_GAP: begin
        if (accept) begin
          shift_d = in_data;
          cnt_d   = PRE_LOAD;
          state_d = S_PRE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRE: begin
        if (cnt_q == '0) begin
          state_d = S_DATA;
          cnt_d   = DAT_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DATA: begin
        shift_d = shift_q << 1;
        if (cnt_q == '0) state_d = S_GAP;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Line values are computed from the state being entered, then registered.
    pre_sh = PREAMBLE >> cnt_d;
    out_d  = IDLE_BIT;
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (state_d)
      S_PRE: begin
        out_d  = pre_sh[0];
        busy_d = 1'b1;
      end
      S_DATA: begin
        out_d  = shift_d[DATA_W-1];
        busy_d = 1'b1;
      end
      S_GAP:   done_d = 1'b1;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same old values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      out_q   <= IDLE_BIT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_pattern_frame_tx.sv
// Bench for pattern_frame_tx: a default 8-bit instance and a 1-bit/1-preamble instance,
// both compared each cycle against a queue of expected line values built per accepted frame.
module tb_pattern_frame_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid, in_ready, out, busy, frame_done;
  logic [0:0] in_data1;
  logic       in_valid1, in_ready1, out1, busy1, frame_done1;

  always #5 clk = ~clk;

  pattern_frame_tx dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out(out), .busy(busy), .frame_done(frame_done)
  );

  pattern_frame_tx #(.DATA_W(1), .PRE_LEN(1), .PREAMBLE(1'b0), .IDLE_BIT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .out(out1), .busy(busy1), .frame_done(frame_done1)
  );

  typedef struct packed {
    logic line;
    logic busy;
    logic done;
  } line_t;

  localparam line_t IDLE_L = '{1'b1, 1'b0, 1'b0};

  line_t q8[$];
  line_t q1[$];
  line_t cur8, cur1;
  int    errors = 0;
  int    checks = 0;
  int    cyc    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void push_line(input bit ch, input line_t l);
    if (ch == 1'b0) q8.push_back(l);
    else            q1.push_back(l);
  endfunction

  // A frame is simply: preamble bits MSB first, data bits MSB first, one idle-level gap bit.
  function automatic void add_frame(input bit ch, input int pre_len, input int data_w,
                                    input logic [31:0] pre, input logic [31:0] word);
    for (int i = pre_len - 1; i >= 0; i--) push_line(ch, '{pre[i], 1'b1, 1'b0});
    for (int i = data_w - 1; i >= 0; i--) push_line(ch, '{word[i], 1'b1, 1'b0});
    push_line(ch, '{1'b1, 1'b0, 1'b1});
  endfunction

  task automatic check_outputs();
    check("out8",   out,        cur8.line);
    check("busy8",  busy,       cur8.busy);
    check("done8",  frame_done, cur8.done);
    check("ready8", in_ready,   q8.size() == 0);
    check("out1",   out1,        cur1.line);
    check("busy1",  busy1,       cur1.busy);
    check("done1",  frame_done1, cur1.done);
    check("ready1", in_ready1,   q1.size() == 0);
  endtask

  // One clock: the source may hand over a word only when the current frame has nothing left queued.
  task automatic cycle(input logic v, input logic [7:0] d, input logic v1, input logic d1);
    logic acc8, acc1;
    in_valid  = v;
    in_data   = d;
    in_valid1 = v1;
    in_data1  = d1;
    acc8 = v  && (q8.size() == 0);
    acc1 = v1 && (q1.size() == 0);
    @(posedge clk);
    cyc++;
    if (acc8) add_frame(1'b0, 3, 8, 32'b010, {24'h0, d});
    if (acc1) add_frame(1'b1, 1, 1, 32'b0, {31'h0, d1});
    cur8 = (q8.size() > 0) ? q8.pop_front() : IDLE_L;
    cur1 = (q1.size() > 0) ? q1.pop_front() : IDLE_L;
    #1;
    check_outputs();
  endtask

  initial begin
    logic [11:0] bits;
    int          done_at[$];

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_valid1 = 1'b0;
    in_data1  = '0;
    cur8      = IDLE_L;
    cur1      = IDLE_L;
    #12;
    check_outputs();
    reset = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Single frame 8'hA5, also compared against the literal line pattern.
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    bits = {11'h0, out};
    for (int i = 0; i < 11; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      bits = {bits[10:0], out};
    end
    check("a5_line", bits, 12'b010_10100101_1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Back-to-back FF then 00 with in_valid held through the GAP edge.
    for (int i = 0; i < 26; i++) begin
      cycle(i <= 12, (i == 0) ? 8'hFF : 8'h00, 1'b0, 1'b0);
      if (frame_done) done_at.push_back(cyc);
    end
    check("b2b_pulses", done_at.size(), 2);
    if (done_at.size() == 2) check("b2b_period", done_at[1] - done_at[0], 12);

    // Stall: data churns while busy; only the word present at the GAP edge is taken next.
    for (int i = 0; i < 26; i++)
      cycle(i <= 12, (i == 0) ? 8'h3C : (i == 12) ? 8'h81 : 8'($urandom), 1'b0, 1'b0);

    // Asynchronous reset during the 4th data bit of 8'hA5.
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("pre_abort_busy", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    q8.delete();
    q1.delete();
    cur8 = IDLE_L;
    cur1 = IDLE_L;
    check("abort_out",   out,        1'b1);
    check("abort_busy",  busy,       1'b0);
    check("abort_ready", in_ready,   1'b1);
    check("abort_done",  frame_done, 1'b0);
    #2 reset = 1'b0;
    for (int i = 0; i < 2; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Minimal instance, continuous valid: frame period is 3 cycles.
    done_at.delete();
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 8'h00, i < 9, 1'b1);
      if (frame_done1) done_at.push_back(cyc);
    end
    check("w1_pulses", done_at.size(), 3);
    for (int i = 1; i < done_at.size(); i++) check("w1_period", done_at[i] - done_at[i-1], 3);

    // Random traffic on both instances.
    for (int i = 0; i < 400; i++)
      cycle(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0, 1'($urandom));
    for (int i = 0; i < 14; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
